// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of a UART transmitter. Each grant goes out as a
// header byte {4'hA, port}, the payload bytes, then an XOR checksum of the payload.
module uart_tx_arbiter #(
    parameter int unsigned NumPorts   = 4,
    parameter int unsigned MaxPayload = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NumPorts-1:0]   i_req_valid,
    input  logic [8*NumPorts-1:0] i_req_data,
    input  logic [NumPorts-1:0]   i_req_last,
    output logic [NumPorts-1:0]   o_req_ready,
    output logic                  o_tx_valid,
    output logic [7:0]            o_tx_data,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic [3:0]            o_grant_id,
    output logic                  o_truncated
);
    localparam int unsigned CntW = $clog2(MaxPayload + 1);

    typedef enum logic [1:0] {StIdle, StHeader, StPayload, StCheck} state_e;

    state_e          state_q, state_d;
    logic [3:0]      grant_q, grant_d;
    logic [3:0]      last_grant_q, last_grant_d;
    logic [7:0]      csum_q, csum_d;
    logic [CntW-1:0] count_q, count_d;
    logic            trunc_q, trunc_d;

    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      sel_data;
    logic [3:0]      arb_pick;
    logic [4:0]      arb_cand;
    logic            arb_found;
    logic            tx_fire;

    // Signals of the currently granted port.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (grant_q == 4'(p)) begin
                sel_valid = i_req_valid[p];
                sel_last  = i_req_last[p];
                sel_data  = i_req_data[8*p +: 8];
            end
        end
    end

    // First valid port searching upward from last_grant + 1, wrapping at NumPorts.
    always_comb begin
        arb_pick  = last_grant_q;
        arb_cand  = '0;
        arb_found = 1'b0;
        for (int unsigned i = 1; i <= NumPorts; i++) begin
            arb_cand = 5'(last_grant_q) + 5'(i);
            if (arb_cand >= 5'(NumPorts)) begin
                arb_cand = arb_cand - 5'(NumPorts);
            end
            for (int unsigned p = 0; p < NumPorts; p++) begin
                if (!arb_found && arb_cand == 5'(p) && i_req_valid[p]) begin
                    arb_pick  = 4'(p);
                    arb_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_tx_valid  = 1'b0;
        o_tx_data   = '0;
        o_req_ready = '0;
        unique case (state_q)
            StHeader: begin
                o_tx_valid = 1'b1;
                o_tx_data  = {4'hA, grant_q};
            end
            StPayload: begin
                o_tx_valid = sel_valid;
                o_tx_data  = sel_data;
                for (int unsigned p = 0; p < NumPorts; p++) begin
                    o_req_ready[p] = (grant_q == 4'(p)) && i_tx_ready;
                end
            end
            StCheck: begin
                o_tx_valid = 1'b1;
                o_tx_data  = csum_q;
            end
            default: ;
        endcase
    end

    assign tx_fire = o_tx_valid && i_tx_ready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        csum_d       = csum_q;
        count_d      = count_q;
        trunc_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|i_req_valid) begin
                    grant_d = arb_pick;
                    state_d = StHeader;
                end
            end
            StHeader: begin
                if (tx_fire) begin
                    csum_d  = '0;
                    count_d = '0;
                    state_d = StPayload;
                end
            end
            StPayload: begin
                if (tx_fire) begin
                    csum_d  = csum_q ^ sel_data;
                    count_d = count_q + CntW'(1);
                    if (sel_last) begin
                        state_d = StCheck;
                    end else if (count_d == CntW'(MaxPayload)) begin
                        state_d = StCheck;
                        trunc_d = 1'b1;
                    end
                end
            end
            StCheck: begin
                if (tx_fire) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= 4'(NumPorts - 1);
            csum_q       <= '0;
            count_q      <= '0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            csum_q       <= csum_d;
            count_q      <= count_d;
            trunc_q      <= trunc_d;
        end
    end

    assign o_busy      = (state_q != StIdle);
    assign o_grant_id  = grant_q;
    assign o_truncated = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, scored against a
// packet-level model of the framed UART byte stream and round-robin grant order.
module tb_uart_tx_arbiter;
    localparam int unsigned NumPorts   = 4;
    localparam int unsigned MaxPayload = 4;
    localparam int unsigned MemDepth   = 256;

    logic                  CLK         = 1'b0;
    logic                  RST         = 1'b0;
    logic [NumPorts-1:0]   i_req_valid = '0;
    logic [8*NumPorts-1:0] i_req_data  = '0;
    logic [NumPorts-1:0]   i_req_last  = '0;
    logic [NumPorts-1:0]   o_req_ready;
    logic                  o_tx_valid;
    logic [7:0]            o_tx_data;
    logic                  i_tx_ready  = 1'b0;
    logic                  o_busy;
    logic [3:0]            o_grant_id;
    logic                  o_truncated;

    uart_tx_arbiter #(
        .NumPorts  (NumPorts),
        .MaxPayload(MaxPayload)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .i_req_valid(i_req_valid),
        .i_req_data (i_req_data),
        .i_req_last (i_req_last),
        .o_req_ready(o_req_ready),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_grant_id (o_grant_id),
        .o_truncated(o_truncated)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Per-port sources {last, data}; the driver and the model keep separate read indices.
    logic [8:0]          src_mem [NumPorts][MemDepth];
    int                  src_tail [NumPorts];
    int                  drv_head [NumPorts];
    int                  exp_head [NumPorts];
    logic [NumPorts-1:0] hold_off;
    int                  valid_pct;
    int                  ready_mode;   // 0 always, 1 one cycle in three, 2 random

    logic [3:0]          rr_last;
    logic [3:0]          cur_id;
    int                  ph;           // 0 header, 1 payload, 2 checksum
    int                  pay_n;
    logic [7:0]          csum_exp;
    logic                trunc_exp;
    logic                busy_prev;
    logic [NumPorts-1:0] valid_prev;
    int                  pkts;
    int                  busy_cycles;
    int                  trunc_pulses;
    logic [7:0]          rx_log[$];
    logic [7:0]          rx_expect[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [3:0] rr_pick(input logic [NumPorts-1:0] v, input logic [3:0] last);
        for (int i = 1; i <= NumPorts; i++) begin
            int c;
            c = (int'(last) + i) % NumPorts;
            if (v[c]) return 4'(c);
        end
        return last;
    endfunction

    task automatic push_byte(input int p, input logic [7:0] d, input logic l);
        src_mem[p][src_tail[p]] = {l, d};
        src_tail[p]++;
    endtask

    task automatic model_clear();
        for (int p = 0; p < NumPorts; p++) begin
            src_tail[p] = 0;
            drv_head[p] = 0;
            exp_head[p] = 0;
        end
        hold_off     = '0;
        rr_last      = 4'(NumPorts - 1);
        cur_id       = '0;
        ph           = 0;
        pay_n        = 0;
        csum_exp     = '0;
        trunc_exp    = 1'b0;
        busy_prev    = 1'b0;
        valid_prev   = '0;
        pkts         = 0;
        busy_cycles  = 0;
        trunc_pulses = 0;
        rx_log.delete();
        i_req_valid  = '0;
        i_req_last   = '0;
    endtask

    task automatic score_byte(input logic [7:0] b);
        logic [8:0] e;
        case (ph)
            0: begin
                check_eq("header", 32'(b), 32'({4'hA, cur_id}));
                csum_exp = '0;
                pay_n    = 0;
                ph       = 1;
            end
            1: begin
                check_eq("payload_avail", 32'(exp_head[cur_id] < src_tail[cur_id]), 32'd1);
                e = src_mem[cur_id][exp_head[cur_id] % MemDepth];
                check_eq("payload", 32'(b), 32'(e[7:0]));
                exp_head[cur_id]++;
                csum_exp ^= e[7:0];
                pay_n++;
                if (e[8]) begin
                    ph = 2;
                end else if (pay_n == MaxPayload) begin
                    ph        = 2;
                    trunc_exp = 1'b1;
                end
            end
            default: begin
                check_eq("checksum", 32'(b), 32'(csum_exp));
                rr_last = cur_id;
                ph      = 0;
                pkts++;
            end
        endcase
    endtask

    task automatic monitor();
        check_eq("ready_onehot", 32'($countones(o_req_ready) <= 1), 32'd1);
        if (!i_tx_ready) check_eq("ready_under_bp", 32'(o_req_ready), 32'd0);
        check_eq("truncated", 32'(o_truncated), 32'(trunc_exp));
        trunc_exp = 1'b0;
        if (o_truncated) trunc_pulses++;
        if (o_busy) busy_cycles++;
        // Arbitration happened in the previous (idle) cycle.
        if (o_busy && !busy_prev) begin
            cur_id = rr_pick(valid_prev, rr_last);
            check_eq("grant_id", 32'(o_grant_id), 32'(cur_id));
        end
        for (int p = 0; p < NumPorts; p++) begin
            if (i_req_valid[p] && o_req_ready[p]) drv_head[p]++;
        end
        if (o_tx_valid && i_tx_ready) begin
            rx_log.push_back(o_tx_data);
            score_byte(o_tx_data);
        end
        busy_prev  = o_busy;
        valid_prev = i_req_valid;
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
        cyc++;
        for (int p = 0; p < NumPorts; p++) begin
            if (drv_head[p] < src_tail[p] && !hold_off[p] && $urandom_range(99) < valid_pct) begin
                i_req_valid[p]        = 1'b1;
                i_req_data[8*p +: 8]  = src_mem[p][drv_head[p]][7:0];
                i_req_last[p]         = src_mem[p][drv_head[p]][8];
            end else begin
                i_req_valid[p]        = 1'b0;
                i_req_data[8*p +: 8]  = 8'($urandom);
                i_req_last[p]         = 1'($urandom);
            end
        end
        case (ready_mode)
            0:       i_tx_ready = 1'b1;
            1:       i_tx_ready = (cyc % 3 == 0);
            default: i_tx_ready = ($urandom_range(99) < 65);
        endcase
        @(negedge CLK);
        if (RST) monitor();
    endtask

    task automatic start_test(input int vpct, input int rmode);
        RST = 1'b0;
        model_clear();
        valid_pct  = vpct;
        ready_mode = rmode;
        repeat (2) cycle();
        RST = 1'b1;
    endtask

    task automatic run_pkts(input string tag, input int n, input int budget);
        int k = 0;
        while (pkts < n && k < budget) begin
            cycle();
            k++;
        end
        check_eq({tag, "_done"}, 32'(pkts >= n), 32'd1);
    endtask

    task automatic run_until_head(input string tag, input int p, input int n);
        int k = 0;
        while (exp_head[p] < n && k < 100) begin
            cycle();
            k++;
        end
        check_eq({tag, "_reach"}, 32'(exp_head[p] >= n), 32'd1);
    endtask

    task automatic check_rx(input string tag);
        check_eq({tag, "_len"}, 32'(rx_log.size()), 32'(rx_expect.size()));
        for (int i = 0; i < rx_expect.size() && i < rx_log.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(rx_log[i]), 32'(rx_expect[i]));
        end
    endtask

    initial begin
        int first_tx;
        int n_exp;

        // Reset state
        start_test(100, 0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check_eq("rst_tx_data", 32'(o_tx_data), 32'd0);
        check_eq("rst_req_ready", 32'(o_req_ready), 32'd0);
        check_eq("rst_grant_id", 32'(o_grant_id), 32'd0);
        check_eq("rst_truncated", 32'(o_truncated), 32'd0);

        // Single packet: header one cycle after first valid, 5 busy cycles
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b0);
        push_byte(0, 8'h33, 1'b1);
        first_tx = -1;
        for (int k = 1; k <= 20 && pkts < 1; k++) begin
            cycle();
            if (first_tx < 0 && o_tx_valid) first_tx = k;
        end
        check_eq("single_latency", 32'(first_tx), 32'd2);
        check_eq("single_busy", 32'(busy_cycles), 32'd5);
        rx_expect = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h00};
        check_rx("single");

        // Fairness between ports 0 and 2; each 1-byte packet costs 3 busy + 1 idle cycle
        start_test(100, 0);
        for (int i = 0; i < 4; i++) begin
            push_byte(0, 8'(8'h10 + i), 1'b1);
            push_byte(2, 8'(8'h20 + i), 1'b1);
        end
        run_pkts("fair", 8, 200);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("fair_hdr%0d", i), 32'(rx_log[3*i]),
                     (i % 2 == 1) ? 32'hA2 : 32'hA0);
        end
        check_eq("fair_busy", 32'(busy_cycles), 32'd24);

        // Backpressure
        start_test(100, 1);
        push_byte(3, 8'h5A, 1'b0);
        push_byte(3, 8'hC3, 1'b1);
        run_pkts("bp", 1, 100);
        rx_expect = '{8'hA3, 8'h5A, 8'hC3, 8'h99};
        check_rx("bp");

        // Truncation at MaxPayload = 4
        start_test(100, 0);
        for (int i = 1; i <= 6; i++) push_byte(1, 8'(i), (i == 6));
        run_pkts("trunc", 2, 100);
        rx_expect = '{8'hA1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'hA1, 8'h05, 8'h06, 8'h03};
        check_rx("trunc");
        check_eq("trunc_pulses", 32'(trunc_pulses), 32'd1);

        // Reset mid-payload after a port-1 packet has moved the round-robin pointer
        start_test(100, 0);
        push_byte(1, 8'h77, 1'b1);
        run_pkts("pre_rst", 1, 50);
        push_byte(3, 8'h31, 1'b0);
        push_byte(3, 8'h32, 1'b0);
        push_byte(3, 8'h33, 1'b1);
        run_until_head("mid_rst", 3, 2);
        RST = 1'b0;
        cycle();
        check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
        check_eq("mid_rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check_eq("mid_rst_req_ready", 32'(o_req_ready), 32'd0);
        check_eq("mid_rst_grant_id", 32'(o_grant_id), 32'd0);
        model_clear();
        RST = 1'b1;
        push_byte(0, 8'h0F, 1'b1);
        push_byte(2, 8'h2F, 1'b1);
        run_pkts("post_rst", 2, 50);
        rx_expect = '{8'hA0, 8'h0F, 8'h0F, 8'hA2, 8'h2F, 8'h2F};
        check_rx("post_rst");

        // Source stall holds the grant while another port waits
        start_test(100, 0);
        push_byte(2, 8'h41, 1'b0);
        push_byte(2, 8'h42, 1'b0);
        push_byte(2, 8'h43, 1'b0);
        push_byte(2, 8'h44, 1'b1);
        run_until_head("stall", 2, 2);
        hold_off[2] = 1'b1;
        push_byte(0, 8'h05, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_eq("stall_grant", 32'(o_grant_id), 32'd2);
            check_eq("stall_busy", 32'(o_busy), 32'd1);
        end
        hold_off[2] = 1'b0;
        run_pkts("stall", 2, 100);
        rx_expect = '{8'hA2, 8'h41, 8'h42, 8'h43, 8'h44, 8'h04, 8'hA0, 8'h05, 8'h05};
        check_rx("stall");

        // Randomized traffic: sparse valids and random backpressure, then full rate
        for (int r = 0; r < 2; r++) begin
            start_test((r == 0) ? 80 : 100, (r == 0) ? 2 : 0);
            n_exp = 0;
            for (int p = 0; p < NumPorts; p++) begin
                int npk;
                npk = (p == 0) ? $urandom_range(1, 6) : $urandom_range(0, 6);
                for (int k = 0; k < npk; k++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    n_exp += (len > MaxPayload) ? 2 : 1;
                    for (int b = 0; b < len; b++) push_byte(p, 8'($urandom), (b == len - 1));
                end
            end
            run_pkts($sformatf("rand%0d", r), n_exp, 4000);
            for (int p = 0; p < NumPorts; p++) begin
                check_eq($sformatf("rand%0d_drain%0d", r, p), 32'(exp_head[p]), 32'(src_tail[p]));
                check_eq($sformatf("rand%0d_accept%0d", r, p), 32'(drv_head[p]),
                         32'(src_tail[p]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter sharing the single UART transmit byte stream between up to 16 on-chip byte producers, such as the VGA frame dumper and debug/status reporters. It sits directly upstream of the UART transmitter. It drives the transmitter's write-enable and data byte, and obeys its buffer-not-full flag. Each granted packet is framed on the wire as a header byte, then the payload, then an XOR checksum, so the host can demultiplex the sources.

## Interface
- NumPorts, 4, number of requesters; legal range 2..16.
- MaxPayload, 64, maximum payload bytes per packet before forced termination; legal range 1..255.
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-low.
- i_req_valid  in  NumPorts  per-port byte valid.
- i_req_data  in  8*NumPorts  per-port byte; port p occupies bits [8p+7:8p].
- i_req_last  in  NumPorts  per-port end-of-packet marker, qualified by i_req_valid.
- o_req_ready  out  NumPorts  per-port byte accept; at most one bit high.
- o_tx_valid  out  1  byte write request to the UART (its i_ready).
- o_tx_data  out  8  byte to the UART (its i_frame).
- i_tx_ready  in  1  UART buffer not full (its o_ready).
- o_busy  out  1  high whenever the state is not IDLE.
- o_grant_id  out  4  currently or most recently granted port.
- o_truncated  out  1  one-cycle pulse when a packet is force-terminated at MaxPayload.

## Operation
- Transfer rules:
  - A UART transfer occurs on a cycle with o_tx_valid && i_tx_ready.
  - A source transfer occurs on a cycle with i_req_valid[p] && o_req_ready[p].
- FSM states: IDLE, HEADER, PAYLOAD, CHECK.
- IDLE:
  - o_tx_valid=0 and o_req_ready=0.
  - If any i_req_valid bit is set, register grant = the first valid port searching upward from last_grant+1 (mod NumPorts), then go to HEADER.
- HEADER:
  - o_tx_valid=1, o_tx_data={4'hA, grant[3:0]}.
  - On UART transfer: clear checksum and byte count, go to PAYLOAD.
- PAYLOAD (combinational pass-through):
  - o_tx_valid = i_req_valid[grant].
  - o_tx_data = i_req_data[grant].
  - o_req_ready[grant] = i_tx_ready; all other o_req_ready bits are 0.
  - On each transfer: checksum ^= byte and count += 1.
  - If i_req_last[grant] is set on the transfer, go to CHECK.
  - Otherwise, if this was the MaxPayload-th byte, go to CHECK and assert o_truncated for the next cycle.
- CHECK:
  - o_tx_valid=1, o_tx_data=checksum.
  - On UART transfer: last_grant <= grant, go to IDLE.
- Truncation: bytes remaining after a truncated packet form a new packet the next time that port is granted.
- Grant hold: a granted port holds the grant until its packet ends. A deasserted i_req_valid in PAYLOAD stalls the arbiter; there is no timeout.
- Checksum width: 8 bits, XOR of payload bytes only; the header is excluded. The byte counter is $clog2(MaxPayload+1) bits wide.

## Timing
- Reset values: state=IDLE, o_tx_valid=0, o_tx_data=0, o_req_ready=0, o_busy=0, o_grant_id=0, o_truncated=0, checksum=0, count=0, last_grant=NumPorts-1 (so port 0 wins first).
- Reset mid-packet returns to IDLE on the next edge with no checksum emitted. The UART shares RST, so the partial packet is discarded on both sides.
- Latency: first valid at IDLE, then HEADER is presented the next cycle.
- Payload throughput is 1 byte/cycle while i_tx_ready=1.
- Per-packet overhead is 3 cycles: IDLE, HEADER, CHECK. Back-to-back packets always pass through one IDLE cycle.
- i_tx_ready=0 in HEADER or CHECK holds o_tx_valid and o_tx_data stable. i_tx_ready=0 in PAYLOAD forces o_req_ready to 0, so no byte is lost or duplicated.
- A request arriving in any state other than IDLE waits; arbitration happens only in IDLE.
- o_grant_id updates on entry to HEADER and holds through IDLE.

## Test plan
- Single packet: port 0 sends 0x11, 0x22, 0x33 with last on 0x33, i_tx_ready=1 -> UART receives 0xA0, 0x11, 0x22, 0x33, 0x00; o_busy high for 5 cycles.
- Fairness: ports 0 and 2 continuously offer 1-byte packets -> headers alternate 0xA0, 0xA2, 0xA0, 0xA2; port 1 is never granted.
- Backpressure: port 3 sends 0x5A, 0xC3 (last) while i_tx_ready toggles 1,0,0,1,... -> UART receives exactly 0xA3, 0x5A, 0xC3, 0x99, and o_req_ready[3] is never high while i_tx_ready=0.
- Truncation, MaxPayload=4: port 1 streams 0x01..0x06 with no last until 0x06 -> UART receives 0xA1, 0x01, 0x02, 0x03, 0x04, 0x04 with one o_truncated pulse, then 0xA1, 0x05, 0x06, 0x03.
- Reset mid-PAYLOAD: RST=0 after the second payload byte -> next cycle state is IDLE, o_tx_valid=0, o_req_ready=0, last_grant=NumPorts-1; the next request from port 0 is granted first.
- Source stall: port 2 deasserts valid for 10 cycles mid-packet while port 0 requests -> no grant change; port 0 is served only after port 2's checksum.
